chip8_sprite_draw: RTL and testbench

- Executes the CHIP-8 DXYN sprite draw as a client on the memory block's video request port.
- Fetches N sprite rows from RAM starting at I, then XORs each row into the 64x32 1bpp VRAM with a read-modify-write.
- Reports pixel collision for VF.
- Sits between the processor's execute stage and chip8_memory. The processor pulses start and waits for done.

---
 rtl/chip8_sprite_draw_if.sv | 32 +++
 rtl/chip8_sprite_draw.sv | 191 +++++++++++++++++++
 tb/tb_chip8_sprite_draw.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_sprite_draw_if.sv
// chip8_sprite_draw_if
//   Video request port between the sprite draw engine and chip8_memory.
//   master : sprite draw engine (drives request, receives response)
//   slave  : memory block
//   mem_addr_out  request address (RAM byte or VRAM byte index)
//   mem_we_out    1 = write
//   mem_valid_out one-cycle request pulse
//   mem_data_out  write data
//   mem_type_out  0 = RAM, 1 = VRAM
//   mem_ready_in  memory can accept a request
//   mem_valid_in  outstanding request completed
//   mem_data_in   read data, valid with mem_valid_in
interface chip8_sprite_draw_if;
   logic [15:0] mem_addr_out;
   logic        mem_we_out;
   logic        mem_valid_out;
   logic [7:0]  mem_data_out;
   logic        mem_type_out;
   logic        mem_ready_in;
   logic        mem_valid_in;
   logic [7:0]  mem_data_in;

   modport master (
      output mem_addr_out, mem_we_out, mem_valid_out, mem_data_out, mem_type_out,
      input  mem_ready_in, mem_valid_in, mem_data_in
   );

   modport slave (
      input  mem_addr_out, mem_we_out, mem_valid_out, mem_data_out, mem_type_out,
      output mem_ready_in, mem_valid_in, mem_data_in
   );
endinterface

// File: rtl/chip8_sprite_draw.sv
// chip8_sprite_draw
//   CHIP-8 DXYN engine. Fetches N sprite rows from RAM at I, XORs each row
//   into the 64x32 1bpp VRAM by read-modify-write of at most two VRAM bytes
//   per row, and reports pixel collision for VF.
//   clk_in, rst_in       clock, synchronous active-high reset
//   start_in             one-cycle draw request (ignored while busy_out)
//   x_in, y_in, n_in     Vx, Vy, row count
//   i_in                 sprite base address
//   busy_out, done_out   draw in progress / one-cycle completion pulse
//   collision_out        VF result, held until the next accepted start
//   mem                  video request port (master side)
//   WRAP                 0 = clip at right/bottom edge, 1 = wrap
//   WIDTH                memory data width, must be 8
module chip8_sprite_draw #(
   parameter int WRAP  = 0,
   parameter int WIDTH = 8
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      start_in,
   input  logic [7:0]                x_in,
   input  logic [7:0]                y_in,
   input  logic [3:0]                n_in,
   input  logic [11:0]               i_in,
   output logic                      busy_out,
   output logic                      done_out,
   output logic                      collision_out,
   chip8_sprite_draw_if.master       mem
);

   typedef enum logic [2:0] {
      S_IDLE, S_SPR_RD, S_L_RD, S_L_WR, S_R_RD, S_R_WR, S_NEXT, S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [5:0]       x0_q;
   logic [4:0]       y0_q;
   logic [3:0]       n_q, r_q;
   logic [11:0]      i_q;
   logic [WIDTH-1:0] spr_q, old_q;
   logic             pend_q, coll_q;

   logic             accept, rsp, can_issue, row_end;
   logic [5:0]       y_abs;
   logic [4:0]       y_row;
   logic [2:0]       col, col_r, off;
   logic             r_clip, l_need, r_need;
   logic [WIDTH-1:0] spr_cur, lmask, rmask;
   logic [2*WIDTH-1:0] mask_pair;

   logic             issue, issue_we, issue_type;
   logic [15:0]      issue_addr;
   logic [7:0]       issue_data;

   // Only the low bits of Vx/Vy select the start pixel.
   logic unused_ok;
   assign unused_ok = &{1'b0, x_in[7:6], y_in[7:5]};

   // DONE also accepts a start: busy_out is already low there.
   assign accept    = start_in && (state_q == S_IDLE || state_q == S_DONE);
   assign rsp       = pend_q && mem.mem_valid_in;
   assign can_issue = !pend_q && mem.mem_ready_in;

   assign y_abs  = {1'b0, y0_q} + {2'b00, r_q};
   assign y_row  = y_abs[4:0];
   assign col    = x0_q[5:3];
   assign off    = x0_q[2:0];
   assign col_r  = col + 3'd1;
   assign r_clip = (WRAP == 0) && (col == 3'd7);

   // Masks are needed in the sprite-read response cycle to pick the next
   // state, before the sprite byte lands in spr_q.
   assign spr_cur   = (state_q == S_SPR_RD) ? mem.mem_data_in : spr_q;
   assign mask_pair = {spr_cur, {WIDTH{1'b0}}} >> off;
   assign lmask     = mask_pair[2*WIDTH-1:WIDTH];
   assign rmask     = mask_pair[WIDTH-1:0];
   assign l_need    = (lmask != '0);
   assign r_need    = (rmask != '0) && !r_clip;

   assign row_end = (r_q == n_q) || ((WRAP == 0) && (y_abs > 6'd31));

   always_comb begin
      state_d    = state_q;
      issue      = 1'b0;
      issue_we   = 1'b0;
      issue_type = 1'b0;
      issue_addr = 16'h0000;
      issue_data = 8'h00;
      case (state_q)
         S_IDLE: if (accept) state_d = S_SPR_RD;
         S_SPR_RD: begin
            issue_addr = {4'h0, i_q + {8'h00, r_q}};
            if (!pend_q) begin
               if (row_end) state_d = S_DONE;
               else         issue   = mem.mem_ready_in;
            end else if (mem.mem_valid_in) begin
               state_d = l_need ? S_L_RD : (r_need ? S_R_RD : S_NEXT);
            end
         end
         S_L_RD: begin
            issue      = can_issue;
            issue_type = 1'b1;
            issue_addr = {8'h00, y_row, col};
            if (rsp) state_d = S_L_WR;
         end
         S_L_WR: begin
            issue      = can_issue;
            issue_we   = 1'b1;
            issue_type = 1'b1;
            issue_addr = {8'h00, y_row, col};
            issue_data = old_q ^ lmask;
            if (rsp) state_d = r_need ? S_R_RD : S_NEXT;
         end
         S_R_RD: begin
            issue      = can_issue;
            issue_type = 1'b1;
            issue_addr = {8'h00, y_row, col_r};
            if (rsp) state_d = S_R_WR;
         end
         S_R_WR: begin
            issue      = can_issue;
            issue_we   = 1'b1;
            issue_type = 1'b1;
            issue_addr = {8'h00, y_row, col_r};
            issue_data = old_q ^ rmask;
            if (rsp) state_d = S_NEXT;
         end
         S_NEXT: state_d = S_SPR_RD;
         S_DONE: state_d = accept ? S_SPR_RD : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q           <= S_IDLE;
         x0_q              <= '0;
         y0_q              <= '0;
         n_q               <= '0;
         r_q               <= '0;
         i_q               <= '0;
         spr_q             <= '0;
         old_q             <= '0;
         pend_q            <= 1'b0;
         coll_q            <= 1'b0;
         mem.mem_valid_out <= 1'b0;
         mem.mem_addr_out  <= '0;
         mem.mem_we_out    <= 1'b0;
         mem.mem_type_out  <= 1'b0;
         mem.mem_data_out  <= '0;
      end else begin
         state_q           <= state_d;
         mem.mem_valid_out <= issue;
         if (accept) begin
            x0_q   <= x_in[5:0];
            y0_q   <= y_in[4:0];
            n_q    <= n_in;
            i_q    <= i_in;
            r_q    <= '0;
            coll_q <= 1'b0;
         end
         if (state_q == S_NEXT) r_q <= r_q + 4'd1;
         // Request fields stay put until the next issue, so they are held
         // for the whole time the request is outstanding.
         if (issue) begin
            pend_q           <= 1'b1;
            mem.mem_addr_out <= issue_addr;
            mem.mem_we_out   <= issue_we;
            mem.mem_type_out <= issue_type;
            mem.mem_data_out <= issue_data;
         end else if (rsp) begin
            pend_q <= 1'b0;
         end
         if (rsp && state_q == S_SPR_RD) spr_q <= mem.mem_data_in;
         if (rsp && state_q == S_L_RD) begin
            old_q <= mem.mem_data_in;
            if ((mem.mem_data_in & lmask) != '0) coll_q <= 1'b1;
         end
         if (rsp && state_q == S_R_RD) begin
            old_q <= mem.mem_data_in;
            if ((mem.mem_data_in & rmask) != '0) coll_q <= 1'b1;
         end
      end
   end

   assign busy_out      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done_out      = (state_q == S_DONE);
   assign collision_out = coll_q;

endmodule

// File: tb/tb_chip8_sprite_draw.sv
// tb_chip8_sprite_draw
//   Two engines (clip and wrap) share stimulus; a memory model serves the
//   selected one. Expected VRAM, collision and request counts come from a
//   pixel-level DXYN model.
module tb_chip8_sprite_draw;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start0, start1;
   logic [7:0]  x, y;
   logic [3:0]  n;
   logic [11:0] i;
   logic        busy0, done0, coll0, busy1, done1, coll1;
   bit          w;
   logic        rdy, vin;
   logic [7:0]  din;

   chip8_sprite_draw_if if0();
   chip8_sprite_draw_if if1();

   chip8_sprite_draw #(.WRAP(0), .WIDTH(8)) dut0 (
      .clk_in(clk), .rst_in(rst), .start_in(start0), .x_in(x), .y_in(y), .n_in(n), .i_in(i),
      .busy_out(busy0), .done_out(done0), .collision_out(coll0), .mem(if0));
   chip8_sprite_draw #(.WRAP(1), .WIDTH(8)) dut1 (
      .clk_in(clk), .rst_in(rst), .start_in(start1), .x_in(x), .y_in(y), .n_in(n), .i_in(i),
      .busy_out(busy1), .done_out(done1), .collision_out(coll1), .mem(if1));

   assign if0.mem_ready_in = !w && rdy;
   assign if0.mem_valid_in = !w && vin;
   assign if0.mem_data_in  = din;
   assign if1.mem_ready_in = w && rdy;
   assign if1.mem_valid_in = w && vin;
   assign if1.mem_data_in  = din;

   logic        busy_s, done_s, coll_s, m_valid, m_we, m_typ;
   logic [15:0] m_addr;
   logic [7:0]  m_wdata;
   assign busy_s  = w ? busy1 : busy0;
   assign done_s  = w ? done1 : done0;
   assign coll_s  = w ? coll1 : coll0;
   assign m_valid = w ? if1.mem_valid_out : if0.mem_valid_out;
   assign m_we    = w ? if1.mem_we_out    : if0.mem_we_out;
   assign m_typ   = w ? if1.mem_type_out  : if0.mem_type_out;
   assign m_addr  = w ? if1.mem_addr_out  : if0.mem_addr_out;
   assign m_wdata = w ? if1.mem_data_out  : if0.mem_data_out;

   typedef struct {
      logic [15:0] addr;
      logic        we;
      logic        typ;
      logic [7:0]  data;
   } req_t;

   req_t        log_q[$];
   logic [7:0]  ram [4096];
   logic [7:0]  vram [256];
   logic [7:0]  exp_vram [256];
   bit          pix [32][64];
   bit          exp_coll;
   int          exp_reqs;
   int          checks = 0, errors = 0;
   int          lat_lo = 1, lat_hi = 3;
   bit          m_pend = 1'b0;
   int          m_dly;
   req_t        m_cur;

   // Memory model: one call per cycle at the falling edge, before any
   // stimulus change, so rdy here is what the DUT sampled last rising edge.
   task automatic step();
      bit was_pend;
      was_pend = m_pend;
      vin = 1'b0;
      din = 8'h00;
      if (m_pend) begin
         if (m_dly == 0) begin
            vin    = 1'b1;
            m_pend = 1'b0;
            if (m_cur.we) vram[m_cur.addr[7:0]] = m_cur.data;
            else din = m_cur.typ ? vram[m_cur.addr[7:0]] : ram[m_cur.addr[11:0]];
         end else begin
            m_dly--;
         end
      end
      if (m_valid === 1'b1) begin
         checks++;
         if (!rdy || was_pend) begin
            errors++;
            $display("FAIL handshake: request with ready=%b outstanding=%b, want ready=1 outstanding=0", rdy, was_pend);
         end
         m_cur.addr = m_addr; m_cur.we = m_we; m_cur.typ = m_typ; m_cur.data = m_wdata;
         log_q.push_back(m_cur);
         m_pend = 1'b1;
         m_dly  = int'($urandom_range(lat_hi, lat_lo)) - 1;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      step();
   endtask

   task automatic clear_vram();
      for (int b = 0; b < 256; b++) vram[b] = 8'h00;
   endtask

   // DXYN at pixel level on a 64x32 bitmap.
   task automatic model_draw(input bit wrap, input logic [7:0] xv, input logic [7:0] yv,
                             input logic [3:0] nv, input logic [11:0] iv);
      int x0, y0, yy, xx;
      logic [7:0] s;
      bit colhit [8];
      for (int b = 0; b < 256; b++)
         for (int k = 0; k < 8; k++) pix[b / 8][(b % 8) * 8 + (7 - k)] = vram[b][k];
      exp_coll = 1'b0;
      exp_reqs = 0;
      x0 = int'(xv) % 64;
      y0 = int'(yv) % 32;
      for (int r = 0; r < int'(nv); r++) begin
         yy = y0 + r;
         if (!wrap && yy > 31) break;
         yy = yy % 32;
         s = ram[(int'(iv) + r) % 4096];
         exp_reqs++;
         for (int c = 0; c < 8; c++) colhit[c] = 1'b0;
         for (int b = 0; b < 8; b++) begin
            if (s[7 - b]) begin
               xx = x0 + b;
               if (wrap || xx <= 63) begin
                  xx = xx % 64;
                  colhit[xx / 8] = 1'b1;
                  if (pix[yy][xx]) exp_coll = 1'b1;
                  pix[yy][xx] = !pix[yy][xx];
               end
            end
         end
         for (int c = 0; c < 8; c++) if (colhit[c]) exp_reqs += 2;
      end
      for (int b = 0; b < 256; b++)
         for (int k = 0; k < 8; k++) exp_vram[b][k] = pix[b / 8][(b % 8) * 8 + (7 - k)];
   endtask

   task automatic do_draw(input bit ws, input logic [7:0] xv, input logic [7:0] yv,
                          input logic [3:0] nv, input logic [11:0] iv,
                          input int hold, input bit restart, output int cyc);
      int nbad, first;
      w = ws; x = xv; y = yv; n = nv; i = iv;
      model_draw(ws, xv, yv, nv, iv);
      log_q.delete();
      if (hold > 0) rdy = 1'b0;
      if (ws) start1 = 1'b1; else start0 = 1'b1;
      tick();
      start0 = 1'b0; start1 = 1'b0;
      checks++;
      if (busy_s !== 1'b1) begin
         errors++;
         $display("FAIL busy_after_start: got %b want 1", busy_s);
      end
      cyc = 0;
      while (done_s !== 1'b1 && cyc < 3000) begin
         if (hold > 0 && cyc == hold) begin
            checks++;
            if (log_q.size() != 0) begin
               errors++;
               $display("FAIL stall: %0d requests while not ready, want 0", log_q.size());
            end
            rdy = 1'b1;
         end
         if (restart && cyc == 2) begin
            x = ~xv; y = ~yv; n = ~nv; i = ~iv;
            if (ws) start1 = 1'b1; else start0 = 1'b1;
         end
         tick();
         start0 = 1'b0; start1 = 1'b0;
         cyc++;
      end
      rdy = 1'b1;
      checks++;
      if (done_s !== 1'b1) begin
         errors++;
         $display("FAIL done_timeout: no done after %0d cycles", cyc);
         rst = 1'b1; tick(); tick(); rst = 1'b0;
         return;
      end
      checks++;
      if (coll_s !== exp_coll || busy_s !== 1'b0) begin
         errors++;
         $display("FAIL done_flags: collision=%b busy=%b want collision=%b busy=0", coll_s, busy_s, exp_coll);
      end
      checks++;
      if (log_q.size() != exp_reqs) begin
         errors++;
         $display("FAIL req_count: got %0d want %0d", log_q.size(), exp_reqs);
      end
      nbad = 0; first = 0;
      for (int b = 255; b >= 0; b--)
         if (vram[b] !== exp_vram[b]) begin nbad++; first = b; end
      checks++;
      if (nbad != 0) begin
         errors++;
         $display("FAIL vram: %0d bytes differ, first at %0d got %h want %h",
                  nbad, first, vram[first], exp_vram[first]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({busy0, done0, coll0, if0.mem_valid_out, if0.mem_we_out, if0.mem_type_out,
           if0.mem_addr_out, if0.mem_data_out} !== 30'd0) begin
         errors++;
         $display("FAIL reset_wrap0: outputs not all zero (addr=%h data=%h busy=%b)",
                  if0.mem_addr_out, if0.mem_data_out, busy0);
      end
      checks++;
      if ({busy1, done1, coll1, if1.mem_valid_out, if1.mem_we_out, if1.mem_type_out,
           if1.mem_addr_out, if1.mem_data_out} !== 30'd0) begin
         errors++;
         $display("FAIL reset_wrap1: outputs not all zero (addr=%h data=%h busy=%b)",
                  if1.mem_addr_out, if1.mem_data_out, busy1);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int cyc;
      clear_vram();
      ram[12'h050] = 8'hF0;
      for (int pass = 0; pass < 2; pass++) begin
         do_draw(1'b0, 8'd0, 8'd0, 4'd1, 12'h050, 0, 1'b0, cyc);
         checks++;
         if (log_q.size() != 3 ||
             log_q[0].addr !== 16'h0050 || log_q[0].we !== 1'b0 || log_q[0].typ !== 1'b0 ||
             log_q[1].addr !== 16'h0000 || log_q[1].we !== 1'b0 || log_q[1].typ !== 1'b1 ||
             log_q[2].addr !== 16'h0000 || log_q[2].we !== 1'b1 || log_q[2].typ !== 1'b1) begin
            errors++;
            $display("FAIL basic_seq%0d: %0d requests, want RAM rd 0050, VRAM rd 0000, VRAM wr 0000", pass, log_q.size());
         end
         checks++;
         if (log_q.size() == 3 && (log_q[2].data !== (pass == 0 ? 8'hF0 : 8'h00) ||
                                   coll_s !== (pass == 1))) begin
            errors++;
            $display("FAIL basic_data%0d: wdata=%h collision=%b", pass, log_q[2].data, coll_s);
         end
      end
      repeat (3) tick();
      checks++;
      if (coll_s !== 1'b1) begin
         errors++;
         $display("FAIL collision_hold: got %b want 1", coll_s);
      end
   endtask

   task automatic test_edges();
      int cyc;
      ram[12'h300] = 8'hFF; ram[12'h301] = 8'hFF; ram[12'h200] = 8'h81;
      clear_vram();
      do_draw(1'b0, 8'd60, 8'd31, 4'd2, 12'h300, 0, 1'b0, cyc);
      checks++;
      if (vram[255] !== 8'h0F || log_q.size() != 3) begin
         errors++;
         $display("FAIL clip: vram[255]=%h reqs=%0d want 0f and 3", vram[255], log_q.size());
      end
      clear_vram();
      do_draw(1'b1, 8'd60, 8'd31, 4'd2, 12'h300, 0, 1'b0, cyc);
      checks++;
      if ({vram[255], vram[248], vram[7], vram[0]} !== 32'h0FF00FF0 || log_q.size() != 10) begin
         errors++;
         $display("FAIL wrap: bytes %h %h %h %h reqs=%0d want 0f f0 0f f0 and 10",
                  vram[255], vram[248], vram[7], vram[0], log_q.size());
      end
      clear_vram();
      do_draw(1'b0, 8'd67, 8'd33, 4'd1, 12'h200, 0, 1'b0, cyc);
      checks++;
      if (vram[8] !== 8'h10 || vram[9] !== 8'h20) begin
         errors++;
         $display("FAIL modulo: vram[8]=%h vram[9]=%h want 10 20", vram[8], vram[9]);
      end
   endtask

   task automatic test_random();
      int cyc;
      logic [11:0] iv;
      lat_lo = 1; lat_hi = 5;
      for (int t = 0; t < 25; t++) begin
         iv = 12'($urandom);
         for (int k = 0; k < 16; k++) ram[(int'(iv) + k) % 4096] = 8'($urandom);
         if (t % 5 == 0) for (int b = 0; b < 256; b++) vram[b] = 8'($urandom);
         do_draw(1'($urandom), 8'($urandom), 8'($urandom), 4'($urandom_range(15, 0)), iv, 0, 1'b0, cyc);
      end
   endtask

   task automatic test_stall_busy();
      int cyc;
      for (int k = 0; k < 16; k++) ram[12'h100 + k] = 8'($urandom);
      do_draw(1'b0, 8'd13, 8'd5, 4'd4, 12'h100, 10, 1'b0, cyc);
      do_draw(1'b1, 8'd61, 8'd29, 4'd6, 12'h100, 0, 1'b1, cyc);
   endtask

   task automatic test_reset_mid();
      int cyc, nreq;
      lat_lo = 5; lat_hi = 5;
      w = 1'b0; x = 8'd21; y = 8'd3; n = 4'd15; i = 12'h100;
      log_q.delete();
      start0 = 1'b1; tick(); start0 = 1'b0;
      cyc = 0;
      while (log_q.size() < 2 && cyc < 200) begin tick(); cyc++; end
      rst = 1'b1;
      tick();
      checks++;
      if ({busy0, done0, coll0, if0.mem_valid_out, if0.mem_we_out, if0.mem_type_out,
           if0.mem_addr_out, if0.mem_data_out} !== 30'd0) begin
         errors++;
         $display("FAIL reset_mid: outputs not zero (busy=%b addr=%h)", busy0, if0.mem_addr_out);
      end
      rst = 1'b0;
      nreq = log_q.size();
      repeat (20) tick();
      checks++;
      if (log_q.size() != nreq || busy0 !== 1'b0 || done0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_quiet: %0d new requests busy=%b done=%b want 0 0 0",
                  log_q.size() - nreq, busy0, done0);
      end
      lat_lo = 1; lat_hi = 5;
   endtask

   task automatic test_n0();
      int cyc;
      do_draw(1'b0, 8'd9, 8'd9, 4'd0, 12'h050, 0, 1'b0, cyc);
      checks++;
      if (cyc != 1 || log_q.size() != 0 || coll_s !== 1'b0) begin
         errors++;
         $display("FAIL n0: done %0d cycles after start, %0d requests, collision=%b; want 2, 0, 0",
                  cyc + 1, log_q.size(), coll_s);
      end
   endtask

   initial begin
      rst = 1'b1; start0 = 1'b0; start1 = 1'b0; w = 1'b0;
      x = '0; y = '0; n = '0; i = '0;
      rdy = 1'b1; vin = 1'b0; din = '0;
      for (int a = 0; a < 4096; a++) ram[a] = 8'h00;
      clear_vram();
      test_reset();
      test_basic();
      test_edges();
      test_random();
      test_stall_busy();
      test_reset_mid();
      test_n0();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
